// File: rtl/trans_conv_pkg.sv
// Shared FSM encodings and elaboration-time helpers for the transposed-conv sequencer.
package trans_conv_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_PACE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trans_conv_pace_timer.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module trans_conv_pace_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired_c
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/trans_conv2d_seq_ctrl.sv
// Sequencer for trans_conv2d_4x4_layer: streams the input map from RAM as paced valid pulses
// and captures every layer output into an output RAM.
module trans_conv2d_seq_ctrl
  import trans_conv_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 16,
  parameter  int unsigned IN_WIDTH      = 8,
  parameter  int unsigned IN_HEIGHT     = 8,
  parameter  int unsigned PIX_PERIOD    = 6,
  parameter  int unsigned ROW_PERIOD    = 22,
  parameter  int unsigned OUT_TOTAL     = 256,
  parameter  int unsigned DRAIN_TIMEOUT = 200,
  localparam int unsigned AW            = clog2(IN_WIDTH * IN_HEIGHT),
  localparam int unsigned OW            = clog2(OUT_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  overflow_err,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  conv_valid_in,
  output logic [DATA_WIDTH-1:0] conv_data_in,
  input  logic                  conv_valid_out,
  input  logic [DATA_WIDTH-1:0] conv_data_out,
  output logic                  out_wr_en,
  output logic [OW-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0] out_wr_data,
  output logic [OW:0]           out_count
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned NPIX = IN_WIDTH * IN_HEIGHT;
  localparam int unsigned CW   = (IN_WIDTH > 1) ? clog2(IN_WIDTH) : 1;
  localparam int unsigned TW   = clog2(max_u(ROW_PERIOD, DRAIN_TIMEOUT));

  // Timer reloads: a pulse is preceded by FETCH and ISSUE, hence the -3.
  localparam logic [TW-1:0] PIX_LOAD   = TW'(PIX_PERIOD - 3);
  localparam logic [TW-1:0] ROW_LOAD   = TW'(ROW_PERIOD - 3);
  localparam logic [TW-1:0] DRAIN_LOAD = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [OW:0]   OUT_FULL   = (OW + 1)'(OUT_TOTAL);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [CW-1:0] col_q, col_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_err_q, timeout_err_d;
  logic          overflow_err_q, overflow_err_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          conv_valid_in_q, conv_valid_in_d;
  logic [DW-1:0] conv_data_in_q, conv_data_in_d;
  logic          out_wr_en_q, out_wr_en_d;
  logic [OW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_wr_data_q, out_wr_data_d;
  logic [OW:0]   out_count_q, out_count_d;

  logic          tmr_load_c;
  logic [TW-1:0] tmr_val_c;
  logic          tmr_expired_c;
  logic          timeout_set_c;
  logic          start_acc_c;
  logic          last_col_c;
  logic          last_pix_c;
  logic          cap_c;
  logic          room_c;

  trans_conv_pace_timer #(
    .TW (TW)
  ) u_pace_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  assign start_acc_c = (state_q == ST_IDLE) && start && !abort;
  assign last_col_c  = (col_q == CW'(IN_WIDTH - 1));
  assign last_pix_c  = (pix_q == AW'(NPIX - 1));

  // Next-state and sequencing outputs.
  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    col_d         = col_q;
    tmr_load_c    = 1'b0;
    tmr_val_c     = '0;
    timeout_set_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pix_d   = '0;
          col_d   = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmr_load_c = 1'b1;
        if (last_pix_c) begin
          state_d   = ST_DRAIN;
          tmr_val_c = DRAIN_LOAD;
        end else begin
          state_d = ST_PACE;
          pix_d   = pix_q + AW'(1);
          if (last_col_c) begin
            col_d     = '0;
            tmr_val_c = ROW_LOAD;
          end else begin
            col_d     = col_q + CW'(1);
            tmr_val_c = PIX_LOAD;
          end
        end
      end
      ST_PACE: begin
        if (tmr_expired_c) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        if (out_count_q == OUT_FULL) begin
          state_d = ST_DONE;
        end else if (conv_valid_out) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = DRAIN_LOAD;
        end else if (tmr_expired_c) begin
          state_d       = ST_DONE;
          timeout_set_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d       = ST_IDLE;
      tmr_load_c    = 1'b0;
      timeout_set_c = 1'b0;
    end

    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_d == ST_DONE);
    mem_rd_en_d     = (state_d == ST_FETCH);
    mem_addr_d      = (state_d == ST_FETCH) ? pix_d : mem_addr_q;
    conv_valid_in_d = (state_q == ST_ISSUE) && !abort;
    conv_data_in_d  = conv_valid_in_d ? mem_rd_data : conv_data_in_q;

    timeout_err_d = timeout_err_q;
    if (start_acc_c) begin
      timeout_err_d = 1'b0;
    end else if (timeout_set_c) begin
      timeout_err_d = 1'b1;
    end
  end

  // Output capture: one registered write per accepted conv output.
  always_comb begin
    cap_c          = conv_valid_out && (state_q != ST_IDLE) && !abort;
    room_c         = (out_count_q != OUT_FULL);
    out_wr_en_d    = cap_c && room_c;
    out_addr_d     = out_addr_q;
    out_wr_data_d  = out_wr_data_q;
    out_count_d    = out_count_q;
    overflow_err_d = overflow_err_q;
    if (start_acc_c) begin
      out_count_d    = '0;
      overflow_err_d = 1'b0;
    end else if (cap_c) begin
      if (room_c) begin
        out_addr_d    = out_count_q[OW-1:0];
        out_wr_data_d = conv_data_out;
        out_count_d   = out_count_q + (OW + 1)'(1);
      end else begin
        overflow_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      pix_q           <= '0;
      col_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      mem_rd_en_q     <= 1'b0;
      mem_addr_q      <= '0;
      conv_valid_in_q <= 1'b0;
      conv_data_in_q  <= '0;
    end else begin
      state_q         <= state_d;
      pix_q           <= pix_d;
      col_q           <= col_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      timeout_err_q   <= timeout_err_d;
      mem_rd_en_q     <= mem_rd_en_d;
      mem_addr_q      <= mem_addr_d;
      conv_valid_in_q <= conv_valid_in_d;
      conv_data_in_q  <= conv_data_in_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_en_q    <= 1'b0;
      out_addr_q     <= '0;
      out_wr_data_q  <= '0;
      out_count_q    <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      out_wr_en_q    <= out_wr_en_d;
      out_addr_q     <= out_addr_d;
      out_wr_data_q  <= out_wr_data_d;
      out_count_q    <= out_count_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = timeout_err_q;
  assign overflow_err  = overflow_err_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_addr      = mem_addr_q;
  assign conv_valid_in = conv_valid_in_q;
  assign conv_data_in  = conv_data_in_q;
  assign out_wr_en     = out_wr_en_q;
  assign out_addr      = out_addr_q;
  assign out_wr_data   = out_wr_data_q;
  assign out_count     = out_count_q;

endmodule

// File: tb/tb_trans_conv2d_seq_ctrl.sv
// Scoreboard bench for trans_conv2d_seq_ctrl: RAM and layer models feed expected-pulse and
// expected-write queues that negedge monitors pop and compare.
module tb_trans_conv2d_seq_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int OW   = 8;
  localparam int NPIX = 64;
  localparam int LAT  = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, timeout_err, overflow_err;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          conv_valid_in;
  logic [DW-1:0] conv_data_in;
  logic          conv_valid_out = 1'b0;
  logic [DW-1:0] conv_data_out = '0;
  logic          out_wr_en;
  logic [OW-1:0] out_addr;
  logic [DW-1:0] out_wr_data;
  logic [OW:0]   out_count;

  trans_conv2d_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .overflow_err   (overflow_err),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .conv_valid_in  (conv_valid_in),
    .conv_data_in   (conv_data_in),
    .conv_valid_out (conv_valid_out),
    .conv_data_out  (conv_data_out),
    .out_wr_en      (out_wr_en),
    .out_addr       (out_addr),
    .out_wr_data    (out_wr_data),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [DW-1:0] data; int t;} pulse_t;
  typedef struct {logic [OW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {logic [DW-1:0] data; int rel;} out_t;

  pulse_t pulse_q[$];
  wr_t    wr_q[$];
  out_t   model_q[$];

  logic [DW-1:0] mem [NPIX];

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int to_rise = -1;
  bit to_prev = 1'b0;
  bit wr_chk = 1'b0;
  bit model_en = 1'b0;
  int model_pix = 0;
  int model_limit = 256;
  int model_extra = 0;
  int emitted = 0;
  int t0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Input RAM with one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Layer model: four outputs per input pulse, released LAT cycles later, one per cycle.
  initial begin
    int   n;
    out_t o;
    forever begin
      @(posedge clk);
      #1;
      conv_valid_out = 1'b0;
      if (model_en && conv_valid_in && model_pix < NPIX) begin
        n = (model_pix == NPIX - 1) ? 4 + model_extra : 4;
        for (int k = 0; k < n; k++) begin
          o.data = 16'(mem[model_pix] * 4 + k);
          o.rel  = cyc + LAT;
          model_q.push_back(o);
        end
        model_pix++;
      end
      if (model_en && model_q.size() > 0 && model_q[0].rel <= cyc) begin
        o = model_q.pop_front();
        if (emitted < model_limit) begin
          conv_valid_out = 1'b1;
          conv_data_out  = o.data;
          if (emitted < 256) wr_q.push_back('{addr: OW'(emitted), data: o.data});
          emitted++;
        end
      end
    end
  end

  // Monitors: pulses, output writes, done and timeout edges.
  always @(negedge clk) begin
    pulse_t p;
    wr_t    w;
    if (conv_valid_in) begin
      if (pulse_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: data %0d at cycle %0d, none required", conv_data_in, cyc);
      end else begin
        p = pulse_q.pop_front();
        check("pulse_data", 64'(conv_data_in), 64'(p.data));
        check("pulse_time", 64'(cyc), 64'(p.t));
      end
      pulses_seen++;
    end
    if (out_wr_en) begin
      last_wr_cyc = cyc;
      if (wr_chk) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, none required", out_addr, out_wr_data);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 64'(out_addr), 64'(w.addr));
          check("wr_data", 64'(out_wr_data), 64'(w.data));
        end
      end
    end
    if (done) done_cnt++;
    if (timeout_err && !to_prev) to_rise = cyc;
    to_prev = timeout_err;
  end

  task automatic fill_mem(input int variant);
    for (int i = 0; i < NPIX; i++) begin
      case (variant)
        0:       mem[i] = 16'(i);
        1:       mem[i] = 16'(i * 3 - 50);
        2:       mem[i] = 16'(1000 - i);
        default: mem[i] = 16'(i + 7);
      endcase
    end
  endtask

  task automatic flush();
    pulse_q.delete();
    wr_q.delete();
    model_q.delete();
  endtask

  // Issue start, check busy latency and queue expected pulses at their exact cycles.
  task automatic begin_layer(input int variant, input int limit, input int extra, input bit chk);
    int t;
    fill_mem(variant);
    flush();
    model_pix = 0; emitted = 0; model_limit = limit; model_extra = extra;
    model_en = 1'b1; wr_chk = chk; done_cnt = 0; pulses_seen = 0; to_rise = -1;
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc;
    t = t0 + 3;
    for (int i = 0; i < NPIX; i++) begin
      pulse_q.push_back('{data: mem[i], t: t});
      t += (i % 8 == 7) ? 22 : 6;
    end
    tick();
    check("busy_at_T0", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    tick();
    check("busy_at_T1", 64'(busy), 64'd1);
  endtask

  task automatic wait_pulses(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (pulses_seen >= n) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_pulses: saw %0d pulses, required %0d", pulses_seen, n);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (done_cnt > 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: no done pulse within budget, required one");
    end else begin
      tick();
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_width", 64'(done), 64'd0);
      repeat (5) tick();
      check("done_count", 64'(done_cnt), 64'd1);
      check("pulses_left", 64'(pulse_q.size()), 64'd0);
      check("writes_left", 64'(wr_q.size()), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_timeout"}, 64'(timeout_err), 64'd0);
    check({tag, "_overflow"}, 64'(overflow_err), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_valid_in"}, 64'(conv_valid_in), 64'd0);
    check({tag, "_data_in"}, 64'(conv_data_in), 64'd0);
    check({tag, "_wr_en"}, 64'(out_wr_en), 64'd0);
    check({tag, "_out_addr"}, 64'(out_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(out_wr_data), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Full layer, RAM = 0..63, with a start while busy after pulse 10.
    begin_layer(0, 256, 0, 1'b1);
    wait_pulses(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check("full_count", 64'(out_count), 64'd256);
    check("full_timeout", 64'(timeout_err), 64'd0);
    check("full_overflow", 64'(overflow_err), 64'd0);

    // Short layer: 250 outputs, drain times out 200 cycles after the last write.
    begin_layer(1, 250, 0, 1'b1);
    wait_done();
    check("short_count", 64'(out_count), 64'd250);
    check("short_timeout", 64'(timeout_err), 64'd1);
    check("short_overflow", 64'(overflow_err), 64'd0);
    check("short_timeout_cycle", 64'(to_rise), 64'(last_wr_cyc + 200));

    // Long layer: 258 outputs, two extras dropped, timeout flag cleared by start.
    begin_layer(2, 258, 2, 1'b1);
    wait_done();
    check("long_count", 64'(out_count), 64'd256);
    check("long_overflow", 64'(overflow_err), 64'd1);
    check("long_timeout", 64'(timeout_err), 64'd0);

    // Abort in the cycle of pulse 30.
    begin_layer(0, 256, 0, 1'b0);
    wait_pulses(30);
    check("abort_pulse_count", 64'(pulses_seen), 64'd30);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    model_en = 1'b0;
    flush();
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid_in", 64'(conv_valid_in), 64'd0);
    check("abort_rd_en", 64'(mem_rd_en), 64'd0);
    check("abort_wr_en", 64'(out_wr_en), 64'd0);
    repeat (60) tick();
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // Restart after abort runs a full layer from address 0.
    begin_layer(3, 256, 0, 1'b1);
    wait_done();
    check("restart_count", 64'(out_count), 64'd256);

    // Reset in the middle of a layer discards everything.
    begin_layer(0, 256, 0, 1'b0);
    wait_pulses(5);
    rst_n = 1'b0;
    model_en = 1'b0;
    flush();
    tick();
    check_all_zero("midreset");
    repeat (2) tick();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) tick();
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_count", 64'(out_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
